// File: rtl/decode_run_mode_pkg.sv
// -----------------------------------------------------------------------------
// decode_run_mode_pkg
// Shared constants for the run-mode bitstream decoder: field widths, FSM state
// encodings, RUNindex limits and the J lookup table used to size each run
// segment (rg = 1 << J[RUNindex]).
// -----------------------------------------------------------------------------
package decode_run_mode_pkg;

    localparam int J_length        = 5;
    localparam int runcount_length = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIT  = 2'd1;
    localparam logic [1:0] ST_TAIL = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [J_length-1:0]        RUN_INDEX_MAX  = 5'd31;
    localparam logic [J_length-1:0]        RUN_INDEX_ZERO = 5'd0;
    localparam logic [runcount_length-1:0] RUN_ZERO       = {runcount_length{1'b0}};
    localparam logic [runcount_length-1:0] RUN_ONE        = {{(runcount_length-1){1'b0}}, 1'b1};

    // J table: number of tail bits that follow a 0 code bit at each RUNindex
    function automatic logic [J_length-1:0] j_of(input logic [J_length-1:0] index);
        logic [J_length-1:0] j_v;
        case (index)
            5'd0,  5'd1,  5'd2,  5'd3:  j_v = 5'd0;
            5'd4,  5'd5,  5'd6,  5'd7:  j_v = 5'd1;
            5'd8,  5'd9,  5'd10, 5'd11: j_v = 5'd2;
            5'd12, 5'd13, 5'd14, 5'd15: j_v = 5'd3;
            5'd16, 5'd17:               j_v = 5'd4;
            5'd18, 5'd19:               j_v = 5'd5;
            5'd20, 5'd21:               j_v = 5'd6;
            5'd22, 5'd23:               j_v = 5'd7;
            5'd24:                      j_v = 5'd8;
            5'd25:                      j_v = 5'd9;
            5'd26:                      j_v = 5'd10;
            5'd27:                      j_v = 5'd11;
            5'd28:                      j_v = 5'd12;
            5'd29:                      j_v = 5'd13;
            5'd30:                      j_v = 5'd14;
            5'd31:                      j_v = 5'd15;
            default:                    j_v = 5'd0;
        endcase
        return j_v;
    endfunction

endpackage

// File: rtl/decode_run_mode_if.sv
// -----------------------------------------------------------------------------
// decode_run_mode_if
// Groups the run command, the code-bit stream handshake and the run result.
//   master: bit unpacker / controller side (drives start, cols_left, bit_in,
//           bit_valid; observes bit_ready and the run result)
//   slave : the decoder
// -----------------------------------------------------------------------------
interface decode_run_mode_if;
    import decode_run_mode_pkg::*;

    logic                        start;
    logic [runcount_length-1:0]  cols_left;
    logic                        bit_in;
    logic                        bit_valid;
    logic                        bit_ready;
    logic                        run_done;
    logic [runcount_length-1:0]  run_length;
    logic                        interrupted;
    logic [J_length-1:0]         run_index_used;
    logic                        busy;

    modport master (
        output start, cols_left, bit_in, bit_valid,
        input  bit_ready, run_done, run_length, interrupted, run_index_used, busy
    );

    modport slave (
        input  start, cols_left, bit_in, bit_valid,
        output bit_ready, run_done, run_length, interrupted, run_index_used, busy
    );

endinterface

// File: rtl/decode_run_mode_run_index_tracker.sv
// -----------------------------------------------------------------------------
// run_index_tracker
// Holds RUNindex across runs with saturating increment (at 31) and decrement
// (at 0), and provides the registered J and rg = 1 << J for the held index.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   clear            return RUNindex to 0 (start of scan)
//   inc / dec        step RUNindex up / down, saturating
//   run_index        current RUNindex
//   j                J[RUNindex]
//   rg               1 << J[RUNindex]
// -----------------------------------------------------------------------------
module run_index_tracker
    import decode_run_mode_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        inc,
    input  logic                        dec,
    output logic [J_length-1:0]         run_index,
    output logic [J_length-1:0]         j,
    output logic [runcount_length-1:0]  rg
);

    logic [J_length-1:0]        run_index_r;
    logic [J_length-1:0]        run_index_nxt_s;
    logic [J_length-1:0]        j_r;
    logic [runcount_length-1:0] rg_r;

    // Next RUNindex: clear wins, then saturating step
    always_comb begin
        run_index_nxt_s = run_index_r;
        if (clear) begin
            run_index_nxt_s = RUN_INDEX_ZERO;
        end else if (inc && (run_index_r != RUN_INDEX_MAX)) begin
            run_index_nxt_s = run_index_r + 5'd1;
        end else if (dec && (run_index_r != RUN_INDEX_ZERO)) begin
            run_index_nxt_s = run_index_r - 5'd1;
        end else begin
            run_index_nxt_s = run_index_r;
        end
    end

    // RUNindex register; J and rg are looked up from the next index so they
    // are valid in the same cycle as the index they belong to
    always_ff @(posedge clk) begin
        if (reset) begin
            run_index_r <= RUN_INDEX_ZERO;
            j_r         <= 5'd0;
            rg_r        <= RUN_ONE;
        end else begin
            run_index_r <= run_index_nxt_s;
            j_r         <= j_of(run_index_nxt_s);
            rg_r        <= RUN_ONE << j_of(run_index_nxt_s);
        end
    end

    assign run_index = run_index_r;
    assign j         = j_r;
    assign rg        = rg_r;

endmodule

// File: rtl/decode_run_mode.sv
// -----------------------------------------------------------------------------
// decode_run_mode
// Run-mode bitstream decoder: consumes code bits one at a time, rebuilds the
// length of the current run, tracks RUNindex across runs and reports whether
// the run ended by interruption or at end of line.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset, overrides all inputs
//   frame_start  start of scan: clears RUNindex, aborts any run without result
//   dif (slave)  start/cols_left command, bit_in/bit_valid/bit_ready stream,
//                run_done/run_length/interrupted/run_index_used result, busy
// -----------------------------------------------------------------------------
module decode_run_mode
    import decode_run_mode_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    decode_run_mode_if.slave  dif
);

    logic [1:0]                 state_r;
    logic [1:0]                 state_nxt_s;
    logic [runcount_length-1:0] run_r;
    logic [runcount_length-1:0] run_nxt_s;
    logic [runcount_length-1:0] rem_r;
    logic [runcount_length-1:0] rem_nxt_s;
    logic [runcount_length-1:0] tail_r;
    logic [runcount_length-1:0] tail_nxt_s;
    logic [J_length-1:0]        tcnt_r;
    logic [J_length-1:0]        tcnt_nxt_s;

    logic                       bit_ready_r;
    logic                       busy_r;
    logic                       run_done_r;
    logic [runcount_length-1:0] run_length_r;
    logic                       interrupted_r;
    logic [J_length-1:0]        run_index_used_r;

    logic                       bit_take_s;
    logic                       inc_s;
    logic                       dec_s;
    logic                       finish_s;
    logic                       fin_intr_s;
    logic [runcount_length-1:0] fin_run_s;
    logic [runcount_length-1:0] add_s;
    logic [runcount_length-1:0] rem_after_s;
    logic [runcount_length-1:0] run_add_s;
    logic [runcount_length-1:0] tail_shift_s;

    logic [J_length-1:0]        run_index_s;
    logic [J_length-1:0]        j_s;
    logic [runcount_length-1:0] rg_s;

    run_index_tracker u_tracker (
        .clk       (clk),
        .reset     (reset),
        .clear     (frame_start),
        .inc       (inc_s),
        .dec       (dec_s),
        .run_index (run_index_s),
        .j         (j_s),
        .rg        (rg_s)
    );

    assign bit_take_s   = bit_ready_r & dif.bit_valid;
    // A 1 bit covers a full rg segment, clipped at the end of the line
    assign add_s        = (rg_s < rem_r) ? rg_s : rem_r;
    assign rem_after_s  = rem_r - add_s;
    assign run_add_s    = run_r + add_s;
    assign tail_shift_s = {tail_r[runcount_length-2:0], dif.bit_in};

    // Next-state, counter and RUNindex step decode
    always_comb begin
        state_nxt_s = state_r;
        run_nxt_s   = run_r;
        rem_nxt_s   = rem_r;
        tail_nxt_s  = tail_r;
        tcnt_nxt_s  = tcnt_r;
        inc_s       = 1'b0;
        dec_s       = 1'b0;
        finish_s    = 1'b0;
        fin_intr_s  = 1'b0;
        fin_run_s   = run_r;
        if (frame_start) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (dif.start) begin
                        run_nxt_s = RUN_ZERO;
                        rem_nxt_s = dif.cols_left;
                        if (dif.cols_left == RUN_ZERO) begin
                            state_nxt_s = ST_DONE;
                            finish_s    = 1'b1;
                            fin_run_s   = RUN_ZERO;
                        end else begin
                            state_nxt_s = ST_HIT;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_HIT: begin
                    if (bit_take_s) begin
                        if (dif.bit_in) begin
                            run_nxt_s = run_add_s;
                            rem_nxt_s = rem_after_s;
                            inc_s     = (add_s == rg_s) && (run_index_s != RUN_INDEX_MAX);
                            if (rem_after_s == RUN_ZERO) begin
                                state_nxt_s = ST_DONE;
                                finish_s    = 1'b1;
                                fin_run_s   = run_add_s;
                            end else begin
                                state_nxt_s = ST_HIT;
                            end
                        end else begin
                            if (j_s == 5'd0) begin
                                state_nxt_s = ST_DONE;
                                finish_s    = 1'b1;
                                fin_intr_s  = 1'b1;
                                fin_run_s   = run_r;
                            end else begin
                                state_nxt_s = ST_TAIL;
                                tcnt_nxt_s  = j_s;
                                tail_nxt_s  = RUN_ZERO;
                            end
                        end
                    end else begin
                        state_nxt_s = ST_HIT;
                    end
                end
                ST_TAIL: begin
                    if (bit_take_s) begin
                        if (tcnt_r == 5'd1) begin
                            // Tail is always shorter than rg, so no clamp against rem
                            state_nxt_s = ST_DONE;
                            run_nxt_s   = run_r + tail_shift_s;
                            finish_s    = 1'b1;
                            fin_intr_s  = 1'b1;
                            fin_run_s   = run_r + tail_shift_s;
                        end else begin
                            state_nxt_s = ST_TAIL;
                            tcnt_nxt_s  = tcnt_r - 5'd1;
                            tail_nxt_s  = tail_shift_s;
                        end
                    end else begin
                        state_nxt_s = ST_TAIL;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                    dec_s       = interrupted_r;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            run_r            <= RUN_ZERO;
            rem_r            <= RUN_ZERO;
            tail_r           <= RUN_ZERO;
            tcnt_r           <= 5'd0;
            bit_ready_r      <= 1'b0;
            busy_r           <= 1'b0;
            run_done_r       <= 1'b0;
            run_length_r     <= RUN_ZERO;
            interrupted_r    <= 1'b0;
            run_index_used_r <= 5'd0;
        end else begin
            state_r     <= state_nxt_s;
            run_r       <= run_nxt_s;
            rem_r       <= rem_nxt_s;
            tail_r      <= tail_nxt_s;
            tcnt_r      <= tcnt_nxt_s;
            bit_ready_r <= (state_nxt_s == ST_HIT) || (state_nxt_s == ST_TAIL);
            busy_r      <= (state_nxt_s != ST_IDLE);
            run_done_r  <= (state_nxt_s == ST_DONE);
            if (finish_s) begin
                run_length_r     <= fin_run_s;
                interrupted_r    <= fin_intr_s;
                run_index_used_r <= run_index_s;
            end
        end
    end

    assign dif.bit_ready      = bit_ready_r;
    assign dif.busy           = busy_r;
    assign dif.run_done       = run_done_r;
    assign dif.run_length     = run_length_r;
    assign dif.interrupted    = interrupted_r;
    assign dif.run_index_used = run_index_used_r;

endmodule

// File: tb/tb_decode_run_mode.sv
module tb_decode_run_mode;
    import decode_run_mode_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_start = 1'b0;

    decode_run_mode_if dif();

    decode_run_mode dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .dif         (dif)
    );

    always #5 clk = ~clk;

    typedef struct {int run; int intr; int used; bit chk_used; int idx_after;} exp_t;
    typedef struct {int run; int intr; int used;} obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    bit   tx_q[$];
    int   obs_rd = 0;
    int   checks = 0;
    int   failures = 0;
    int   bits_taken = 0;
    int   ready_hi = 0;
    int   m_idx = 0;

    localparam int JT [32] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,
                               4,4,5,5,6,6,7,7,8,9,10,11,12,13,14,15};

    function automatic obs_t make_obs(input int r, input int i, input int u);
        obs_t o;
        o.run = r; o.intr = i; o.used = u;
        return o;
    endfunction

    // Result capture and handshake counting, away from the active edge
    always @(negedge clk) begin
        if (dif.run_done === 1'b1)
            obs_q.push_back(make_obs(int'(dif.run_length), int'(dif.interrupted), int'(dif.run_index_used)));
        if (dif.bit_ready === 1'b1 && dif.bit_valid === 1'b1)
            bits_taken <= bits_taken + 1;
        if (dif.bit_ready === 1'b1)
            ready_hi <= ready_hi + 1;
    end

    task automatic push_exp(input int r, input int i, input int u, input bit cu, input int ia);
        exp_t e;
        e.run = r; e.intr = i; e.used = u; e.chk_used = cu; e.idx_after = ia;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start(input int cols);
        dif.start = 1'b1;
        dif.cols_left = cols[15:0];
        @(posedge clk); #1;
        dif.start = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic send_q();
        for (int i = 0; i < tx_q.size(); i++) begin
            int  guard;
            bit  rdy;
            guard = 0;
            dif.bit_valid = 1'b1;
            dif.bit_in = tx_q[i];
            do begin
                @(negedge clk);
                rdy = dif.bit_ready;
                @(posedge clk); #1;
                guard++;
            end while (!rdy && guard < 50);
            if (!rdy) begin
                checks++; failures++;
                $display("FAIL bit_timeout: bit %0d not accepted after %0d cycles", i, guard);
            end
        end
        dif.bit_valid = 1'b0;
    endtask

    task automatic check_result(input string name);
        int   guard;
        exp_t e;
        obs_t o;
        guard = 0;
        while (obs_q.size() <= obs_rd && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (obs_q.size() <= obs_rd) begin
            checks++; failures++;
            $display("FAIL %s_timeout: no run_done within %0d cycles", name, guard);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            @(posedge clk); #1;
            return;
        end
        e = exp_q.pop_front();
        o = obs_q[obs_rd];
        obs_rd++;
        checks++;
        if (o.run !== e.run) begin
            failures++;
            $display("FAIL %s run_length: got %0d expected %0d", name, o.run, e.run);
        end
        checks++;
        if (o.intr !== e.intr) begin
            failures++;
            $display("FAIL %s interrupted: got %0d expected %0d", name, o.intr, e.intr);
        end
        if (e.chk_used) begin
            checks++;
            if (o.used !== e.used) begin
                failures++;
                $display("FAIL %s run_index_used: got %0d expected %0d", name, o.used, e.used);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (int'(dut.u_tracker.run_index_r) !== e.idx_after) begin
            failures++;
            $display("FAIL %s run_index_after: got %0d expected %0d", name, dut.u_tracker.run_index_r, e.idx_after);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (dif.run_done !== 1'b0) begin failures++; $display("FAIL reset run_done: got %b expected 0", dif.run_done); end
        checks++;
        if (dif.busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b expected 0", dif.busy); end
        checks++;
        if (dif.bit_ready !== 1'b0) begin failures++; $display("FAIL reset bit_ready: got %b expected 0", dif.bit_ready); end
        checks++;
        if ({dif.run_length, dif.interrupted, dif.run_index_used} !== 22'd0) begin
            failures++;
            $display("FAIL reset result: got len=%0d intr=%b used=%0d expected all 0",
                     dif.run_length, dif.interrupted, dif.run_index_used);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_interrupt();
        int b0;
        pulse_frame();
        b0 = bits_taken;
        push_exp(4, 1, 4, 1'b1, 3);
        pulse_start(10);
        tx_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        send_q();
        check_result("interrupt");
        checks++;
        if (bits_taken - b0 !== 6) begin failures++; $display("FAIL interrupt bits: got %0d expected 6", bits_taken - b0); end
    endtask

    task automatic test_end_of_line();
        int b0;
        pulse_frame();
        push_exp(4, 0, 3, 1'b1, 4);
        pulse_start(4);
        tx_q = '{1'b1, 1'b1, 1'b1, 1'b1};
        send_q();
        check_result("eol_prep");
        b0 = bits_taken;
        push_exp(5, 0, 6, 1'b1, 6);
        pulse_start(5);
        tx_q = '{1'b1, 1'b1, 1'b1};
        send_q();
        check_result("end_of_line");
        checks++;
        if (bits_taken - b0 !== 3) begin failures++; $display("FAIL end_of_line bits: got %0d expected 3", bits_taken - b0); end
    endtask

    task automatic prep_index8(input string name);
        pulse_frame();
        push_exp(12, 0, 7, 1'b1, 8);
        pulse_start(12);
        tx_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        send_q();
        check_result(name);
    endtask

    task automatic test_tail();
        prep_index8("tail_prep");
        push_exp(2, 1, 8, 1'b1, 7);
        pulse_start(20);
        tx_q = '{1'b0, 1'b1, 1'b0};
        send_q();
        check_result("tail");
    endtask

    task automatic test_zero_cols();
        int r0;
        r0 = ready_hi;
        push_exp(0, 0, 0, 1'b0, 7);
        pulse_start(0);
        @(negedge clk);
        checks++;
        if (dif.run_done !== 1'b1) begin failures++; $display("FAIL zero_cols latency: run_done got %b expected 1", dif.run_done); end
        check_result("zero_cols");
        checks++;
        if (ready_hi - r0 !== 0) begin failures++; $display("FAIL zero_cols bit_ready: high %0d cycles expected 0", ready_hi - r0); end
    endtask

    task automatic test_stall_abort();
        int b0;
        prep_index8("stall_prep");
        push_exp(3, 1, 8, 1'b1, 7);
        pulse_start(20);
        tx_q = '{1'b0, 1'b1};
        send_q();
        b0 = bits_taken;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bits_taken !== b0 || dif.busy !== 1'b1 || dif.bit_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall: taken=%0d busy=%b ready=%b expected taken=%0d busy=1 ready=1",
                     bits_taken, dif.busy, dif.bit_ready, b0);
        end
        tx_q = '{1'b1};
        send_q();
        check_result("stall");
        pulse_start(20);
        tx_q = '{1'b0};
        send_q();
        pulse_frame();
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() !== obs_rd) begin failures++; $display("FAIL abort run_done: got %0d results expected 0", obs_q.size() - obs_rd); end
        checks++;
        if (dif.busy !== 1'b0 || dif.bit_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort idle: busy=%b ready=%b expected 0 0", dif.busy, dif.bit_ready);
        end
        checks++;
        if (dut.u_tracker.run_index_r !== 5'd0) begin failures++; $display("FAIL abort run_index: got %0d expected 0", dut.u_tracker.run_index_r); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation_reset();
        pulse_frame();
        push_exp(33052, 0, 30, 1'b1, 31);
        pulse_start(33052);
        tx_q.delete();
        for (int i = 0; i < 31; i++) tx_q.push_back(1'b1);
        send_q();
        check_result("climb");
        pulse_start(40000);
        tx_q = '{1'b1};
        send_q();
        checks++;
        if (dut.u_tracker.run_index_r !== 5'd31) begin failures++; $display("FAIL saturate run_index: got %0d expected 31", dut.u_tracker.run_index_r); end
        tx_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        send_q();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dif.run_done, dif.busy, dif.bit_ready, dif.run_length, dif.interrupted, dif.run_index_used} !== 25'd0) begin
            failures++;
            $display("FAIL mid_tail_reset outputs: done=%b busy=%b ready=%b len=%0d intr=%b used=%0d expected all 0",
                     dif.run_done, dif.busy, dif.bit_ready, dif.run_length, dif.interrupted, dif.run_index_used);
        end
        checks++;
        if (dut.u_tracker.run_index_r !== 5'd0) begin failures++; $display("FAIL mid_tail_reset run_index: got %0d expected 0", dut.u_tracker.run_index_r); end
        @(posedge clk); #1;
        reset = 1'b0;
        m_idx = 0;
        @(posedge clk); #1;
    endtask

    // Reference model: draws random code bits and builds the expected result
    task automatic gen_run(input int cols);
        int run, rem, rg, add, used, tail;
        bit b;
        tx_q.delete();
        run = 0;
        rem = cols;
        if (cols == 0) begin
            push_exp(0, 0, 0, 1'b0, m_idx);
            return;
        end
        forever begin
            b = ($urandom_range(3, 0) != 0);
            tx_q.push_back(b);
            rg = 1 << JT[m_idx];
            used = m_idx;
            if (b) begin
                add = (rg < rem) ? rg : rem;
                run += add;
                rem -= add;
                if (add == rg && m_idx < 31) m_idx++;
                if (rem == 0) begin
                    push_exp(run, 0, used, 1'b1, m_idx);
                    return;
                end
            end else begin
                tail = 0;
                for (int k = 0; k < JT[used]; k++) begin
                    b = $urandom_range(1, 0);
                    tx_q.push_back(b);
                    tail = tail * 2 + int'(b);
                end
                run += tail;
                if (m_idx > 0) m_idx--;
                push_exp(run, 1, used, 1'b1, m_idx);
                return;
            end
        end
    endtask

    task automatic test_random();
        int cols;
        for (int n = 0; n < 14; n++) begin
            cols = $urandom_range(40, 0);
            gen_run(cols);
            pulse_start(cols);
            send_q();
            check_result("random");
        end
    endtask

    initial begin
        dif.start = 1'b0;
        dif.cols_left = 16'd0;
        dif.bit_in = 1'b0;
        dif.bit_valid = 1'b0;
        test_reset();
        test_interrupt();
        test_end_of_line();
        test_tail();
        test_zero_cols();
        test_stall_abort();
        test_saturation_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
